// File: rtl/debounce.sv
// Switch/button debouncer: a 2-flop synchronizer feeding a 4-state qualification FSM.
// Define DEBOUNCE_BUSY_EN to add busy_o, a registered flag that is high while a level change is being qualified.
module debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic sig_o
`ifdef DEBOUNCE_BUSY_EN
  ,
  output logic busy_o
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_t;

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sig_q, sig_d;
`ifdef DEBOUNCE_BUSY_EN
  logic             busy_q, busy_d;
`endif

  // Next-state logic; the >= compare keeps cnt from ever passing DEB_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HI;
          sig_d   = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LO;
          sig_d   = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
        sig_d   = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_BUSY_EN
  // busy follows the next state so the registered flag lines up with the FSM state.
  always_comb begin
    if ((state_d == WAIT_HI) || (state_d == WAIT_LO)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end
`endif

  // Synchronizer, FSM state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= CNT_ZERO;
      sig_q   <= 1'b0;
`ifdef DEBOUNCE_BUSY_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
`ifdef DEBOUNCE_BUSY_EN
      busy_q  <= busy_d;
`endif
    end
  end

  assign sig_o = sig_q;
`ifdef DEBOUNCE_BUSY_EN
  assign busy_o = busy_q;
`endif

endmodule

// File: tb/tb_debounce.sv
// Scoreboard bench for debounce: the driver pushes the expected output for each edge,
// and a monitor pops and compares it 1 time unit after that edge.
module tb_debounce;

  localparam int DEB = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic sig_i  = 1'b0;
  logic sig_o;
`ifdef DEBOUNCE_BUSY_EN
  logic busy_o;
`endif

  typedef struct packed {
    logic sig;
    logic busy;
  } exp_t;

  exp_t exp_q[$];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   edge_cnt  = 0;
  int   rise_cnt  = 0;
  int   fall_cnt  = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  int   busy_cnt  = 0;
  logic prev_sig  = 1'b0;

  // Reference model: the filter sees sig_i two edges late. The output flips once the
  // trailing run of samples that differ from it reaches DEB.
  logic m_s1  = 1'b0;
  logic m_s2  = 1'b0;
  logic m_out = 1'b0;
  int   m_run = 0;

  debounce #(.DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sig_i  (sig_i),
    .sig_o  (sig_o)
`ifdef DEBOUNCE_BUSY_EN
    ,
    .busy_o (busy_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model_edge(input logic s, input logic r);
    exp_t e;
    logic smp;
    if (!r) begin
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      m_out = 1'b0;
      m_run = 0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = s;
      if (smp != m_out) begin
        m_run++;
        if (m_run == DEB) begin
          m_out = smp;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    e.sig  = m_out;
    e.busy = (m_run > 0);
    return e;
  endfunction

  task automatic step(input logic s, input logic r);
    sig_i  = s;
    resetn = r;
    exp_q.push_back(model_edge(s, r));
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    edge_cnt++;
    if (sig_o && !prev_sig) begin
      rise_cnt++;
      last_rise = edge_cnt;
    end
    if (!sig_o && prev_sig) begin
      fall_cnt++;
      last_fall = edge_cnt;
    end
    prev_sig = sig_o;
`ifdef DEBOUNCE_BUSY_EN
    if (busy_o) busy_cnt++;
`endif
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (sig_o !== e.sig) begin
        n_fail++;
        $display("FAIL sig_o at edge %0d: got %0b, expected %0b", edge_cnt, sig_o, e.sig);
      end
`ifdef DEBOUNCE_BUSY_EN
      n_checks++;
      if (busy_o !== e.busy) begin
        n_fail++;
        $display("FAIL busy_o at edge %0d: got %0b, expected %0b", edge_cnt, busy_o, e.busy);
      end
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   b_r;
    int   b_f;
    int   b_b;
    int   len;
    logic lvl;
    logic rst;

    @(negedge clk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);

    // Clean rising edge after reset
    n   = edge_cnt + 1;
    b_r = rise_cnt;
    b_b = busy_cnt;
    repeat (10) step(1'b1, 1'b1);
    check("rise_latency", last_rise, n + 5);
    check("rise_once", rise_cnt - b_r, 1);
`ifdef DEBOUNCE_BUSY_EN
    check("busy_edges", busy_cnt - b_b, 3);
`endif

    // Return low, then a 3-cycle bounce that must be rejected
    repeat (10) step(1'b0, 1'b1);
    b_r = rise_cnt;
    repeat (3) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    check("short_bounce_no_rise", rise_cnt - b_r, 0);

    // Toggle every cycle, then hold high
    for (int i = 0; i < 20; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
    check("toggle_no_rise", rise_cnt - b_r, 0);
    n = edge_cnt + 1;
    repeat (10) step(1'b1, 1'b1);
    check("rise_after_toggle", last_rise, n + 5);
    check("rise_after_toggle_once", rise_cnt - b_r, 1);

    // Falling edge latency, then a 2-cycle high glitch during WAIT_LO
    n   = edge_cnt + 1;
    b_f = fall_cnt;
    repeat (10) step(1'b0, 1'b1);
    check("fall_latency", last_fall, n + 5);
    check("fall_once", fall_cnt - b_f, 1);
    repeat (10) step(1'b1, 1'b1);
    b_f = fall_cnt;
    b_r = rise_cnt;
    repeat (3) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    check("glitch_no_fall", fall_cnt - b_f, 0);
    check("glitch_no_rise", rise_cnt - b_r, 0);

    // Reset in WAIT_HI with cnt=2 restarts qualification from scratch
    repeat (10) step(1'b0, 1'b1);
    n   = edge_cnt + 1;
    b_r = rise_cnt;
    repeat (4) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    check("reset_requal_latency", last_rise, n + 4 + 6);
    check("reset_requal_once", rise_cnt - b_r, 1);

    // Random bursts with occasional resets
    for (int b = 0; b < 150; b++) begin
      len = $urandom_range(8, 1);
      lvl = 1'($urandom_range(1, 0));
      for (int k = 0; k < len; k++) begin
        rst = ($urandom_range(199, 0) == 0) ? 1'b0 : 1'b1;
        step(lvl, rst);
      end
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
